// File: rtl/adc_spi_captura.sv
// ============================================================================
// adc_spi_captura
// ----------------------------------------------------------------------------
// Serial capture front end for an external 12-bit SPI ADC (PmodAD1 class).
// A free-running sample timer starts one conversion frame every PERIODO clocks.
// During a frame the block drives CS_n low and generates SCLK. It shifts the
// ADC data in MSB first and presents the low ANCHO bits as a parallel sample.
// A one-clock strobe marks the cycle in which the sample is updated.
// dato_out/listo feed the datos/enable inputs of the downstream holding
// register, which runs in the same clock domain.
//
// Optional feature (macro PROMEDIO4_EN):
//   When PROMEDIO4_EN is defined, four consecutive frames are summed.
//   Only the fourth frame strobes. It presents the truncated average.
//   When PROMEDIO4_EN is undefined, every frame strobes its own sample.
//
// Parameters:
//   ANCHO      sample width (ANCHO <= BITS_TRAMA-1)
//   BITS_TRAMA SCLK cycles per frame
//   DIV        clk cycles per SCLK half period (>= 2)
//   PERIODO    clk cycles between conversion starts
//   QUIET      clk cycles CS_n is held high after a frame
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   habilitar  in   1 = free-running sampling, 0 = finish frame then idle
//   sdata      in   ADC serial data
//   cs_n       out  ADC chip select, active low
//   sclk       out  ADC serial clock, idles high
//   dato_out   out  last completed sample, held between strobes
//   listo      out  one-clock strobe, dato_out updated this cycle
// ============================================================================
module adc_spi_captura #(
   parameter int ANCHO      = 12,
   parameter int BITS_TRAMA = 16,
   parameter int DIV        = 4,
   parameter int PERIODO    = 1000,
   parameter int QUIET      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             habilitar,
   input  logic             sdata,
   output logic             cs_n,
   output logic             sclk,
   output logic [ANCHO-1:0] dato_out,
   output logic             listo
);

   localparam int TW = $clog2(PERIODO + 1);
   localparam int DW = $clog2(DIV + 1);
   localparam int BW = $clog2(BITS_TRAMA + 1);
   localparam int QW = $clog2(QUIET + 1);

   localparam logic [TW-1:0] TIMER_MAX = TW'(PERIODO - 1);
   localparam logic [DW-1:0] DIV_MAX   = DW'(DIV - 1);
   localparam logic [BW-1:0] BITS_FIN  = BW'(BITS_TRAMA);
   localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET - 1);

   typedef enum logic [1:0] {
      REPOSO,
      CONVERSION,
      QUIETO
   } estado_t;

   estado_t          estado_q;
   logic [TW-1:0]    timer_q, timer_d;
   logic             tick;
   logic [DW-1:0]    div_q;
   logic [BW-1:0]    bits_q;
   logic [QW-1:0]    quiet_q;
   logic [ANCHO-1:0] shift_q;
   logic [ANCHO-1:0] dato_q;
   logic             cs_n_q;
   logic             sclk_q;
   logic             listo_q;

`ifdef PROMEDIO4_EN
   logic [ANCHO+1:0] acc_q;
   logic [ANCHO+1:0] suma;
   logic [1:0]       tramas_q;

   // Running sum including the frame that is just completing.
   always_comb begin
      suma = acc_q + {2'b00, shift_q};
   end
`endif

   // The sample timer only runs while sampling is enabled.
   // Dropping habilitar parks it at zero, so re-enabling gives a full period
   // before the next frame.
   always_comb begin
      timer_d = timer_q;
      if (!habilitar) begin
         timer_d = '0;
      end else if (timer_q == TIMER_MAX) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + 1'b1;
      end
   end

   assign tick = habilitar && (timer_q == TIMER_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   // Frame sequencer with registered SPI pins and strobe.
   // The shift register is only ANCHO wide, so leading frame bits fall off
   // the top on their own.
   // A tick that arrives outside REPOSO is simply not looked at.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q <= REPOSO;
         cs_n_q   <= 1'b1;
         sclk_q   <= 1'b1;
         div_q    <= '0;
         bits_q   <= '0;
         quiet_q  <= '0;
         shift_q  <= '0;
         dato_q   <= '0;
         listo_q  <= 1'b0;
`ifdef PROMEDIO4_EN
         acc_q    <= '0;
         tramas_q <= '0;
`endif
      end else begin
         listo_q <= 1'b0;
`ifdef PROMEDIO4_EN
         if (!habilitar) begin
            acc_q    <= '0;
            tramas_q <= '0;
         end
`endif
         case (estado_q)
            REPOSO: begin
               cs_n_q <= 1'b1;
               sclk_q <= 1'b1;
               if (tick) begin
                  estado_q <= CONVERSION;
                  cs_n_q   <= 1'b0;
                  div_q    <= '0;
                  bits_q   <= '0;
               end
            end

            CONVERSION: begin
               if (bits_q == BITS_FIN) begin
                  // The last rising edge happened one clock ago; close the frame.
                  estado_q <= QUIETO;
                  cs_n_q   <= 1'b1;
                  sclk_q   <= 1'b1;
                  quiet_q  <= '0;
`ifdef PROMEDIO4_EN
                  if (habilitar) begin
                     if (tramas_q == 2'd3) begin
                        dato_q   <= suma[ANCHO+1:2];
                        listo_q  <= 1'b1;
                        acc_q    <= '0;
                        tramas_q <= '0;
                     end else begin
                        acc_q    <= suma;
                        tramas_q <= tramas_q + 1'b1;
                     end
                  end
`else
                  dato_q  <= shift_q;
                  listo_q <= 1'b1;
`endif
               end else if (div_q == DIV_MAX) begin
                  div_q  <= '0;
                  sclk_q <= ~sclk_q;
                  // The ADC updates sdata on falling edges, so sample on the rise.
                  if (!sclk_q) begin
                     shift_q <= {shift_q[ANCHO-2:0], sdata};
                     bits_q  <= bits_q + 1'b1;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end

            QUIETO: begin
               cs_n_q <= 1'b1;
               sclk_q <= 1'b1;
               if (quiet_q == QUIET_MAX) begin
                  estado_q <= REPOSO;
               end else begin
                  quiet_q <= quiet_q + 1'b1;
               end
            end

            default: begin
               estado_q <= REPOSO;
               cs_n_q   <= 1'b1;
               sclk_q   <= 1'b1;
            end
         endcase
      end
   end

   assign cs_n     = cs_n_q;
   assign sclk     = sclk_q;
   assign dato_out = dato_q;
   assign listo    = listo_q;

endmodule

// File: tb/tb_adc_spi_captura.sv
// ============================================================================
// tb_adc_spi_captura
// ----------------------------------------------------------------------------
// Self-checking bench for adc_spi_captura at default parameters.
// A behavioural ADC model shifts out queued 16-bit frames.
// It drives each bit on a falling SCLK edge, MSB first.
// Each frame queued by the stimulus pushes its expected strobe value into a
// scoreboard queue.
// A monitor on the falling clk edge pops the queue and compares it whenever
// listo is high.
// The monitor also checks strobe latency and the SCLK edge count.
// Build with +define+PROMEDIO4_EN to exercise the averaging variant.
// ============================================================================
module tb_adc_spi_captura;

   logic        clk;
   logic        reset;
   logic        habilitar;
   logic        sdata;
   logic        cs_n;
   logic        sclk;
   logic [11:0] dato_out;
   logic        listo;

   int checks = 0;
   int errors = 0;

   logic [15:0] adcFrames[$];
   logic [11:0] expQ[$];

   int   cycle = 0;
   int   csFallCycle = 0;
   int   sclkRises = 0;
   int   csFalls = 0;
   logic prevCs = 1'b1;
   logic prevSclk = 1'b1;
   logic [11:0] prevDato = '0;
   logic [11:0] expVal;
   logic resetDone = 1'b0;
   int   groupSum = 0;
   int   groupCount = 0;
   int   waited;
   int   fallsBefore;

   adc_spi_captura #(
      .ANCHO(12),
      .BITS_TRAMA(16),
      .DIV(4),
      .PERIODO(1000),
      .QUIET(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .habilitar(habilitar),
      .sdata(sdata),
      .cs_n(cs_n),
      .sclk(sclk),
      .dato_out(dato_out),
      .listo(listo)
   );

   // 10 ns system clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Free-running cycle counter, used for latency measurements.
   always @(posedge clk) begin
      cycle <= cycle + 1;
   end

   task automatic checkOutput(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // Queues one ADC frame and its expected result.
   // mode 0 = completes normally.
   // mode 1 = habilitar is dropped during the frame.
   // mode 2 = the frame is aborted by reset.
   task automatic applyStimulus(input logic [15:0] frame, input int mode);
      adcFrames.push_back(frame);
`ifdef PROMEDIO4_EN
      if (mode == 0) begin
         groupSum += int'(frame[11:0]);
         groupCount++;
         if (groupCount == 4) begin
            expQ.push_back(12'(groupSum >> 2));
            groupSum = 0;
            groupCount = 0;
         end
      end else begin
         groupSum = 0;
         groupCount = 0;
      end
`else
      if (mode != 2) begin
         expQ.push_back(frame[11:0]);
      end
`endif
   endtask

   // Waits a bounded number of clocks for cs_n to fall.
   // Reports how many clocks that took.
   task automatic waitCsFall(input int limit, output int count);
      count = 0;
      while (cs_n && count < limit) begin
         @(negedge clk);
         count++;
      end
   endtask

   // ADC model: sdata toggles during the initial reset.
   // After that, each chip-select falling edge loads the next queued frame.
   // Bits go out MSB first, one per falling SCLK edge.
   initial begin : adcModel
      logic [15:0] frame;
      sdata = 1'b0;
      while (!resetDone) begin
         @(negedge clk);
         sdata = ~sdata;
      end
      forever begin
         @(negedge cs_n);
         frame = (adcFrames.size() > 0) ? adcFrames.pop_front() : 16'h0000;
         sdata = 1'b0;
         for (int i = 15; i >= 0; i--) begin
            @(negedge sclk or posedge cs_n);
            if (cs_n) break;
            sdata = frame[i];
         end
      end
   end

   // Monitor: tracks frame timing and scores every strobe.
   always @(negedge clk) begin
      if (prevCs && !cs_n) begin
         csFallCycle = cycle;
         sclkRises = 0;
         csFalls++;
      end
      if (!cs_n && !prevSclk && sclk) begin
         sclkRises++;
      end
      if (listo) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_strobe: got dato_out=%0h, expected no strobe", dato_out);
         end else begin
            expVal = expQ.pop_front();
            checkOutput("strobe_value", int'(dato_out), int'(expVal));
            checkOutput("strobe_latency", cycle - csFallCycle, 129);
            checkOutput("sclk_rising_edges", sclkRises, 16);
         end
      end
      if (reset && dato_out !== prevDato) begin
         checkOutput("dato_change_with_listo", int'(listo), 1);
      end
      prevCs   = cs_n;
      prevSclk = sclk;
      prevDato = dato_out;
   end

   initial begin
      reset = 1'b0;
      habilitar = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("reset_cs_n", int'(cs_n), 1);
      checkOutput("reset_sclk", int'(sclk), 1);
      checkOutput("reset_dato_out", int'(dato_out), 0);
      checkOutput("reset_listo", int'(listo), 0);

      // Default build: one strobe per frame.
      // Averaged build: group 1 = (0xAC3 + 0x000 + 0xFFF + 0x5A5) / 4
      //   = 8295 / 4 -> 0x819.
      // Group 2 = (100 + 200 + 300 + 401) / 4 = 1001 / 4 -> 250 (0x0FA).
      // 0x5A5 is sent with non-zero leading bits, which must be discarded.
      applyStimulus(16'h0AC3, 0);
      applyStimulus(16'h0000, 0);
      applyStimulus(16'h0FFF, 0);
      applyStimulus(16'hF5A5, 0);
      applyStimulus(16'd100, 0);
      applyStimulus(16'd200, 0);
      applyStimulus(16'd300, 0);
      applyStimulus(16'd401, 0);
      resetDone = 1'b1;

      @(negedge clk);
      habilitar = 1'b1;
      reset = 1'b1;
      waitCsFall(2000, waited);
      checkOutput("first_start_delay", waited, 1000);

      // Frames 2..8 run back to back.
      // Stop 200 clocks after frame 8 started; frame 9 then starts 800 later.
      repeat (7 * 1000 + 200) @(negedge clk);
      applyStimulus(16'h0123, 1);
      waitCsFall(2000, waited);
      checkOutput("frame_spacing", waited, 800);

      // Drop habilitar 40 clocks into frame 9.
      // The frame still finishes, and then no new frame may start.
      repeat (40) @(negedge clk);
      habilitar = 1'b0;
      fallsBefore = csFalls;
      repeat (3100) @(negedge clk);
      checkOutput("idle_no_new_frame", csFalls, fallsBefore);
      checkOutput("idle_cs_n", int'(cs_n), 1);

      // Re-enable: the timer restarts from zero.
      // Reset 60 clocks into the frame; at that point sclk is low.
      applyStimulus(16'h0777, 2);
      @(negedge clk);
      habilitar = 1'b1;
      waitCsFall(2000, waited);
      checkOutput("restart_delay", waited, 1000);
      repeat (60) @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("abort_cs_n", int'(cs_n), 1);
      checkOutput("abort_sclk", int'(sclk), 1);
      checkOutput("abort_listo", int'(listo), 0);
      checkOutput("abort_dato_out", int'(dato_out), 0);
      repeat (5) @(negedge clk);
      reset = 1'b1;

      applyStimulus(16'h0FED, 0);
      waitCsFall(2000, waited);
      checkOutput("start_after_reset", waited, 1000);
      repeat (200) @(negedge clk);
      checkOutput("pending_expectations", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_spi_captura.md
Name: adc_spi_captura

Overview:
- Serial-capture front end for an external 12-bit SPI ADC (PmodAD1-class): generates CS_n/SCLK, shifts in one frame per sample period, presents a parallel sample.
- Sits directly upstream of the team's parametrised enable-D holding register: dato_out drives its datos input, listo drives its enable, one clock domain shared.

Parameters:
- ANCHO, 12, sample width; must equal the downstream register width; ANCHO <= BITS_TRAMA-1.
- BITS_TRAMA, 16, SCLK cycles per frame (leading zeros + ANCHO data bits, MSB first).
- DIV, 4, clk cycles per SCLK half-period (>=2).
- PERIODO, 1000, clk cycles between conversion starts (must exceed one frame + quiet time).
- QUIET, 4, clk cycles CS_n held high after a frame before next start is allowed.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- habilitar  in  1  1 = free-running sampling; 0 = finish current frame, then idle.
- sdata  in  1  ADC serial data.
- cs_n  out  1  ADC chip select, active-low.
- sclk  out  1  ADC serial clock, idles high.
- dato_out  out  ANCHO  last completed sample, held between strobes.
- listo  out  1  one-clk strobe: dato_out updated this cycle.

Behaviour:
- Reset (reset=0, async): state REPOSO, cs_n=1, sclk=1, dato_out=0, listo=0, all counters 0. Reset mid-frame aborts immediately; no strobe; first frame after release starts a full PERIODO later.
- Sample timer: counts 0..PERIODO-1 while habilitar=1, wraps; tick at count PERIODO-1. Held at 0 while habilitar=0.
- FSM states: REPOSO, CONVERSION, QUIETO.
  - REPOSO: cs_n=1, sclk=1. On tick -> CONVERSION, cs_n drops next clk.
  - CONVERSION: sclk toggles every DIV clks, starting with a falling edge DIV clks after cs_n falls. sdata sampled into shift register on the clk where sclk rises 0->1 (the ADC changes data on falling edges). After BITS_TRAMA rising edges -> QUIETO; sclk left high.
  - QUIETO: cs_n=1 for QUIET clks, then -> REPOSO.
- Output: on CONVERSION->QUIETO transition, dato_out <= low ANCHO bits of shift register; listo=1 for exactly that one clk. Leading (BITS_TRAMA-ANCHO) bits are discarded, not checked.
- Latency: listo asserts 1 + 2*DIV*BITS_TRAMA clks after cs_n falls (129 at defaults).
- habilitar falling mid-frame: frame completes and strobes normally; no new frame starts. Rising again: timer restarts from 0.
- Tick arriving outside REPOSO (mis-set PERIODO): ignored, not queued.
- dato_out never changes except with listo=1.

Optional Feature:
- Macro PROMEDIO4_EN.
- Defined: a 2-bit frame counter and (ANCHO+2)-bit accumulator sum four consecutive frames; on the 4th frame dato_out <= accumulator[ANCHO+1:2] (truncating), listo pulses, accumulator clears. Frames 1-3 produce no strobe. Reset and habilitar=0 clear counter and accumulator; partial groups are discarded.
- Not defined: every frame strobes as described above; no accumulator logic present.

Test Plan:
- Reset: hold reset=0 with sdata toggling -> cs_n=1, sclk=1, dato_out=0, listo=0; release, habilitar=1 -> cs_n falls after 1000 clks.
- Single frame: ADC model drives 0000_1010_1100_0011 -> one listo pulse, dato_out=12'hAC3, pulse 129 clks after cs_n falls, exactly 16 sclk rising edges.
- Back-to-back: values 12'h000, 12'hFFF, 12'h5A5 -> three strobes spaced 1000 clks, values in order, dato_out stable between strobes.
- habilitar dropped at clk 40 of a frame -> frame completes with its value, then cs_n stays 1 for >=3000 clks.
- Reset pulse at clk 60 of a frame -> cs_n=1, sclk=1 same clk, no listo, dato_out keeps 0 or prior value cleared to 0.
- PROMEDIO4_EN: frames 100, 200, 300, 401 -> single strobe after 4th, dato_out=250; non-defined build same stimulus -> 4 strobes.
